// File: rtl/wb_interconnect_1xn_pkg.sv
// Shared types and helpers for the single-master / N-slave Wishbone interconnect.
package wb_interconnect_pkg;

  localparam int unsigned MAX_SLAVES = 16;
  localparam int unsigned MAX_ADDR_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    ERROR
  } wb_ic_state_e;

  typedef logic [$clog2(MAX_SLAVES)-1:0] slave_idx_t;
  typedef logic [MAX_ADDR_W-1:0]         wide_addr_t;

  // Callers zero-extend narrower addresses so one helper serves every AW.
  function automatic logic addr_in_range(input wide_addr_t addr,
                                         input wide_addr_t base,
                                         input wide_addr_t limit);
    return (addr >= base) && (addr <= limit);
  endfunction

endpackage

// File: rtl/wb_interconnect_1xn_if.sv
// Wishbone B3 bundle; NP ports are flattened side by side, port i at [i*W +: W].
interface wb_interconnect_1xn_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned NP = 1
);
  logic [NP*AW-1:0]     ADR;
  logic [NP*DW-1:0]     DAT_W;
  logic [NP*(DW/8)-1:0] SEL;
  logic [NP-1:0]        WE;
  logic [NP*3-1:0]      CTI;
  logic [NP*2-1:0]      BTE;
  logic [NP-1:0]        CYC;
  logic [NP-1:0]        STB;
  logic [NP*DW-1:0]     DAT_R;
  logic [NP-1:0]        ACK;
  logic [NP-1:0]        ERR;

  modport master (
    output ADR, DAT_W, SEL, WE, CTI, BTE, CYC, STB,
    input  DAT_R, ACK, ERR
  );

  modport slave (
    input  ADR, DAT_W, SEL, WE, CTI, BTE, CYC, STB,
    output DAT_R, ACK, ERR
  );
endinterface

// File: rtl/wb_interconnect_1xn_addr_decode.sv
// Combinational address decoder: reports a hit and the lowest-index matching region.
module wb_addr_decode
  import wb_interconnect_pkg::*;
#(
  parameter int unsigned             AW          = 32,
  parameter int unsigned             N_SLAVES    = 4,
  parameter logic [N_SLAVES*2*AW-1:0] ADDR_RANGES = '0
) (
  input  logic [AW-1:0] addr,
  output logic          hit,
  output slave_idx_t    idx
);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    // Slave 0's {base,limit} pair sits at the MSB end of ADDR_RANGES.
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (!hit &&
          addr_in_range(wide_addr_t'(addr),
                        wide_addr_t'(ADDR_RANGES[(N_SLAVES-1-i)*2*AW + AW +: AW]),
                        wide_addr_t'(ADDR_RANGES[(N_SLAVES-1-i)*2*AW +: AW]))) begin
        hit = 1'b1;
        idx = slave_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/wb_interconnect_1xn.sv
// Single-master to N-slave Wishbone B3 interconnect with registered decode,
// per-CYC slave lock, unmapped-address ERR and a hung-slave watchdog.
module wb_interconnect_1xn
  import wb_interconnect_pkg::*;
#(
  parameter int unsigned                              WB_ADDR_WIDTH  = 32,
  parameter int unsigned                              WB_DATA_WIDTH  = 32,
  parameter int unsigned                              N_SLAVES       = 4,
  parameter logic [N_SLAVES*2*WB_ADDR_WIDTH-1:0]      ADDR_RANGES    = '0,
  parameter int unsigned                              TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rstn,
  wb_interconnect_1xn_if.slave  m_bus,
  wb_interconnect_1xn_if.master s_bus,
  output logic                  err_unmapped,
  output logic                  err_timeout
);

  localparam int unsigned DW     = WB_DATA_WIDTH;
  localparam int unsigned WDOG_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST =
    WDOG_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  wb_ic_state_e      state_q, state_d;
  slave_idx_t        sel_q, sel_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_unmapped_q, err_unmapped_d;
  logic              err_timeout_q, err_timeout_d;

  logic              dec_hit;
  slave_idx_t        dec_idx;
  logic              req;
  logic              sel_ack, sel_err;
  logic [DW-1:0]     sel_rdata;

  wb_addr_decode #(
    .AW          (WB_ADDR_WIDTH),
    .N_SLAVES    (N_SLAVES),
    .ADDR_RANGES (ADDR_RANGES)
  ) u_decode (
    .addr (m_bus.ADR),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  assign req = m_bus.CYC[0] & m_bus.STB[0];

  always_comb begin
    sel_ack   = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (sel_q == slave_idx_t'(i)) begin
        sel_ack   = s_bus.ACK[i];
        sel_err   = s_bus.ERR[i];
        sel_rdata = s_bus.DAT_R[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= IDLE;
      sel_q          <= '0;
      wdog_q         <= '0;
      err_unmapped_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      wdog_q         <= wdog_d;
      err_unmapped_q <= err_unmapped_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    wdog_d         = '0;
    err_unmapped_d = 1'b0;
    err_timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (dec_hit) begin
            state_d = ACTIVE;
            sel_d   = dec_idx;
          end else begin
            state_d        = ERROR;
            err_unmapped_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (!m_bus.CYC[0]) begin
          state_d = IDLE;
        end else if (m_bus.STB[0] && !sel_ack && !sel_err) begin
          // A response in the threshold cycle wins, so the abort only fires on a silent cycle.
          if (TIMEOUT_CYCLES != 0 && wdog_q == WDOG_LAST) begin
            state_d       = ERROR;
            err_timeout_d = 1'b1;
          end else if (wdog_q != '1) begin
            wdog_d = wdog_q + WDOG_W'(1);
          end else begin
            wdog_d = wdog_q;
          end
        end
      end
      ERROR: begin
        if (!m_bus.CYC[0]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_bus.ADR   = {N_SLAVES{m_bus.ADR}};
  assign s_bus.DAT_W = {N_SLAVES{m_bus.DAT_W}};
  assign s_bus.SEL   = {N_SLAVES{m_bus.SEL}};
  assign s_bus.WE    = {N_SLAVES{m_bus.WE}};
  assign s_bus.CTI   = {N_SLAVES{m_bus.CTI}};
  assign s_bus.BTE   = {N_SLAVES{m_bus.BTE}};

  always_comb begin
    s_bus.CYC   = '0;
    s_bus.STB   = '0;
    m_bus.DAT_R = '0;
    m_bus.ACK   = '0;
    m_bus.ERR   = '0;
    case (state_q)
      ACTIVE: begin
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
          if (sel_q == slave_idx_t'(i)) begin
            s_bus.CYC[i] = m_bus.CYC[0];
            s_bus.STB[i] = m_bus.STB[0];
          end
        end
        m_bus.DAT_R  = sel_rdata;
        m_bus.ACK[0] = sel_ack;
        m_bus.ERR[0] = sel_err & ~sel_ack;
      end
      ERROR: m_bus.ERR[0] = req;
      default: ;
    endcase
  end

  assign err_unmapped = err_unmapped_q;
  assign err_timeout  = err_timeout_q;

endmodule
